// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned RETRY_W    = 2;
    localparam int unsigned LOST_CNT_W = 8;

    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_MAX_RETRIES    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises the PLL: pulses its reset, qualifies lock, and gates the system reset.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  soft_req,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  pll_fail,
    output logic [STATE_W-1:0]    state_o,
    output logic [RETRY_W-1:0]    retry_cnt,
    output logic [LOST_CNT_W-1:0] lost_cnt
);

    localparam int unsigned CNT_W =
        $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    logic                  locked_s;
    pll_state_e            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [RETRY_W-1:0]    retry_q,     retry_d;
    logic [LOST_CNT_W-1:0] lost_q,      lost_d;
    logic                  pll_rst_q,   pll_rst_d;
    logic                  sys_rst_n_q, sys_rst_n_d;
    logic                  pll_fail_q,  pll_fail_d;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    // Next-state logic; soft_req overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        lost_d  = lost_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_RESET_PLL;
                    end
                end
            end
            ST_STABLE: begin
                if (!locked_s) state_d = ST_WAIT_LOCK;
                else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) begin
                    if (lost_q != {LOST_CNT_W{1'b1}}) lost_d = lost_q + LOST_CNT_W'(1);
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAIL: ;
            default: state_d = ST_RESET_PLL;
        endcase

        if (soft_req) begin
            state_d = ST_RESET_PLL;
            retry_d = '0;
            lost_d  = lost_q;
        end

        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;

        if (state_d != state_q || soft_req) cnt_d = '0;
        else if (state_q == ST_RUN || state_q == ST_FAIL) cnt_d = cnt_q;

        pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_rst_n_d = (state_d == ST_RUN);
        pll_fail_d  = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            pll_fail_q  <= pll_fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign pll_fail  = pll_fail_q;
    assign state_o   = state_q;
    assign retry_cnt = retry_q;
    assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened timing parameters.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       locked;
    logic       soft_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_fail;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .locked    (locked),
        .soft_req  (soft_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .pll_fail  (pll_fail),
        .state_o   (state_o),
        .retry_cnt (retry_cnt),
        .lost_cnt  (lost_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Samples with pll_rst high, starting from the current one.
    task automatic measure_pulse(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            tick(1);
        end
    endtask

    // Edges spent in WAIT_LOCK before leaving it.
    task automatic measure_wait(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (state_o === 3'd1 && n < 100);
    endtask

    // Assumes locked was raised just after the previous edge.
    task automatic check_release(input string name);
        tick(10);
        checks++;
        if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL %s early release got %b want 0", name, sys_rst_n); end
        tick(1);
        checks++;
        if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL %s release got %b want 1", name, sys_rst_n); end
        checks++;
        if (state_o !== 3'd3) begin errors++; $display("FAIL %s run state got %0d want 3", name, state_o); end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0; locked = 1'b0; soft_req = 1'b0;
        tick(3);
        checks++;
        if ({pll_rst, sys_rst_n, pll_fail} !== 3'b100) begin errors++; $display("FAIL reset_outs got %b want 100", {pll_rst, sys_rst_n, pll_fail}); end
        checks++;
        if ({state_o, retry_cnt, lost_cnt} !== 13'd0) begin errors++; $display("FAIL reset_regs got %0h want 0", {state_o, retry_cnt, lost_cnt}); end
        rst_n = 1'b1;
        measure_pulse(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL reset_pulse got %0d want 4", n); end
        checks++;
        if (state_o !== 3'd1) begin errors++; $display("FAIL reset_wait got %0d want 1", state_o); end
    endtask

    task automatic test_nominal;
        tick(5);
        locked = 1'b1;
        tick(3);
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL nominal_stable got %0d want 2", state_o); end
        tick(7);
        checks++;
        if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL nominal early got %b want 0", sys_rst_n); end
        tick(1);
        checks++;
        if ({sys_rst_n, pll_rst, state_o} !== 5'b10011) begin errors++; $display("FAIL nominal_run got %b want 10011", {sys_rst_n, pll_rst, state_o}); end
    endtask

    task automatic test_lock_loss;
        int n;
        locked = 1'b0;
        tick(2);
        checks++;
        if ({sys_rst_n, state_o} !== 4'b1011) begin errors++; $display("FAIL loss_hold got %b want 1011", {sys_rst_n, state_o}); end
        tick(1);
        checks++;
        if ({sys_rst_n, pll_rst, state_o} !== 5'b01000) begin errors++; $display("FAIL loss_drop got %b want 01000", {sys_rst_n, pll_rst, state_o}); end
        checks++;
        if (lost_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt got %0d want 1", lost_cnt); end
        measure_pulse(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL loss_pulse got %0d want 4", n); end
    endtask

    task automatic test_stable_glitch;
        locked = 1'b1;
        tick(3);
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL glitch_stable got %0d want 2", state_o); end
        tick(5);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL glitch_hold got %0d want 2", state_o); end
        tick(1);
        checks++;
        if ({state_o, retry_cnt} !== 5'b00100) begin errors++; $display("FAIL glitch_wait got %b want 00100", {state_o, retry_cnt}); end
        tick(1);
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL glitch_restable got %0d want 2", state_o); end
        tick(7);
        checks++;
        if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL glitch early got %b want 0", sys_rst_n); end
        tick(1);
        checks++;
        if ({sys_rst_n, state_o, retry_cnt} !== 6'b101100) begin errors++; $display("FAIL glitch_run got %b want 101100", {sys_rst_n, state_o, retry_cnt}); end
    endtask

    task automatic test_timeout_fail;
        int n;
        locked = 1'b0;
        tick(3);
        checks++;
        if ({state_o, lost_cnt} !== {3'd0, 8'd2}) begin errors++; $display("FAIL to_entry got %0h want 002", {state_o, lost_cnt}); end
        for (int i = 0; i < 3; i++) begin
            measure_pulse(n);
            checks++;
            if (n != 4) begin errors++; $display("FAIL to_pulse%0d got %0d want 4", i, n); end
            checks++;
            if (retry_cnt !== 2'(i)) begin errors++; $display("FAIL to_retry%0d got %0d want %0d", i, retry_cnt, i); end
            measure_wait(n);
            checks++;
            if (n != 20) begin errors++; $display("FAIL to_wait%0d got %0d want 20", i, n); end
        end
        checks++;
        if ({state_o, pll_fail, pll_rst, sys_rst_n, retry_cnt} !== 8'b10011010) begin
            errors++; $display("FAIL to_fail got %b want 10011010", {state_o, pll_fail, pll_rst, sys_rst_n, retry_cnt});
        end
        tick(5);
        checks++;
        if ({state_o, pll_fail} !== 4'b1001) begin errors++; $display("FAIL to_sticky got %b want 1001", {state_o, pll_fail}); end
    endtask

    task automatic test_soft_req;
        int n;
        soft_req = 1'b1;
        tick(1);
        soft_req = 1'b0;
        checks++;
        if ({state_o, pll_rst, sys_rst_n, pll_fail, retry_cnt} !== 8'b00010000) begin
            errors++; $display("FAIL soft_entry got %b want 00010000", {state_o, pll_rst, sys_rst_n, pll_fail, retry_cnt});
        end
        measure_pulse(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL soft_pulse got %0d want 4", n); end
        locked = 1'b1;
        check_release("soft_bringup");
        checks++;
        if (lost_cnt !== 8'd2) begin errors++; $display("FAIL soft_lost got %0d want 2", lost_cnt); end
    endtask

    task automatic test_soft_lock_loss;
        int n;
        locked = 1'b0;
        tick(2);
        soft_req = 1'b1;
        tick(1);
        soft_req = 1'b0;
        checks++;
        if ({state_o, pll_rst, sys_rst_n} !== 5'b00010) begin errors++; $display("FAIL coinc_state got %b want 00010", {state_o, pll_rst, sys_rst_n}); end
        checks++;
        if (lost_cnt !== 8'd2) begin errors++; $display("FAIL coinc_lost got %0d want 2", lost_cnt); end
        measure_pulse(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL coinc_pulse got %0d want 4", n); end
        tick(1);
        checks++;
        if (lost_cnt !== 8'd2) begin errors++; $display("FAIL coinc_lost_after got %0d want 2", lost_cnt); end
    endtask

    task automatic test_reset_mid;
        int n;
        locked = 1'b1;
        tick(3);
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL mid_stable got %0d want 2", state_o); end
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pll_rst, sys_rst_n, pll_fail, state_o, retry_cnt} !== 8'b10000000) begin
            errors++; $display("FAIL mid_async got %b want 10000000", {pll_rst, sys_rst_n, pll_fail, state_o, retry_cnt});
        end
        checks++;
        if (lost_cnt !== 8'd0) begin errors++; $display("FAIL mid_lost got %0d want 0", lost_cnt); end
        tick(2);
        rst_n = 1'b1;
        measure_pulse(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL mid_pulse got %0d want 4", n); end
        tick(1);
        checks++;
        if ({state_o, lost_cnt} !== {3'd2, 8'd0}) begin errors++; $display("FAIL mid_restart got %0h want 200", {state_o, lost_cnt}); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_stable_glitch();
        test_timeout_fail();
        test_soft_req();
        test_soft_lock_loss();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
